// File: rtl/syn_vga_pkg.sv
// Shared VGA pixel-path constants and types, used by the fetch engine,
// the line buffer and the VGA timing FSM.
package syn_vga_pkg;

   localparam int PXL_W      = 16;
   localparam int DEPTH_DEF  = 1024;
   localparam int LOW_WM_DEF = 256;

   typedef logic [PXL_W-1:0] pxl_t;

endpackage

// File: rtl/syn_vga_drvr_lb_intf.sv
// Control/status link between the VGA driver and its pixel line buffer.
interface syn_vga_drvr_lb_intf;

   logic vga_drvr_en;
   logic bffr_overflow;
   logic bffr_underflow;

   modport line_bffr (
      input  vga_drvr_en,
      output bffr_overflow,
      output bffr_underflow
   );

   modport drvr (
      output vga_drvr_en,
      input  bffr_overflow,
      input  bffr_underflow
   );

endinterface

// File: rtl/syn_ram_sdp.sv
// Simple dual-port RAM: one write port, one registered read port.
// The array is not reset so it maps onto block RAM.
module syn_ram_sdp #(
   parameter int DW = 16,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [0:(1<<AW)-1];

   // Same-address read/write returns the old word, which the full-FIFO
   // simultaneous push/pop relies on.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/syn_vga_line_bffr.sv
// Pixel line FIFO between the SRAM fetch engine and the VGA pixel FSM, with
// low-watermark refill request, sticky overflow/underflow and flush on disable.
module syn_vga_line_bffr
   import syn_vga_pkg::*;
#(
   parameter int DEPTH  = DEPTH_DEF,
   parameter int PTR_W  = $clog2(DEPTH),
   parameter int LOW_WM = LOW_WM_DEF
) (
   input  logic                         clk_ir,
   input  logic                         rst_il,
   syn_vga_drvr_lb_intf.line_bffr       lb_intf,
   input  logic                         wr_en,
   input  pxl_t                         wr_pxl,
   output logic                         fetch_req,
   input  logic                         rd_en,
   output pxl_t                         rd_pxl,
   output logic                         rd_valid,
   output logic                         full,
   output logic                         empty,
   output logic [PTR_W:0]               occ
);

   localparam logic [PTR_W:0] LOW_WM_C = LOW_WM[PTR_W:0];
   localparam logic [PTR_W:0] DEPTH_C  = DEPTH[PTR_W:0];

   logic [PTR_W-1:0] wptr_reg;
   logic [PTR_W-1:0] rptr_reg;
   logic [PTR_W:0]   occ_reg;
   logic [PTR_W:0]   occ_next;
   logic             ovf_reg;
   logic             unf_reg;
   logic             fetch_req_reg;
   logic             rd_valid_reg;
   logic             pxl_zero_reg;
   logic             drvr_en;
   logic             wr_ok;
   logic             rd_ok;
   pxl_t             ram_q;

   assign drvr_en = lb_intf.vga_drvr_en;
   assign full    = (occ_reg == DEPTH_C);
   assign empty   = (occ_reg == '0);

   // A pop on a full FIFO frees the slot the push needs in the same cycle.
   always_comb begin
      wr_ok    = wr_en && (!full || rd_en);
      rd_ok    = rd_en && !empty;
      occ_next = occ_reg;
      if (wr_ok && !rd_ok)
         occ_next = occ_reg + (PTR_W+1)'(1);
      else if (rd_ok && !wr_ok)
         occ_next = occ_reg - (PTR_W+1)'(1);
   end

   syn_ram_sdp #(
      .DW (PXL_W),
      .AW (PTR_W)
   ) u_ram (
      .clk   (clk_ir),
      .we    (drvr_en && wr_ok),
      .waddr (wptr_reg),
      .wdata (wr_pxl),
      .re    (drvr_en && rd_ok),
      .raddr (rptr_reg),
      .rdata (ram_q)
   );

   always_ff @(posedge clk_ir or negedge rst_il) begin
      if (!rst_il) begin
         wptr_reg      <= '0;
         rptr_reg      <= '0;
         occ_reg       <= '0;
         ovf_reg       <= 1'b0;
         unf_reg       <= 1'b0;
         fetch_req_reg <= 1'b0;
         rd_valid_reg  <= 1'b0;
         pxl_zero_reg  <= 1'b1;
      end else if (!drvr_en) begin
         wptr_reg      <= '0;
         rptr_reg      <= '0;
         occ_reg       <= '0;
         ovf_reg       <= 1'b0;
         unf_reg       <= 1'b0;
         fetch_req_reg <= 1'b0;
         rd_valid_reg  <= 1'b0;
         pxl_zero_reg  <= 1'b1;
      end else begin
         if (wr_ok)
            wptr_reg <= wptr_reg + PTR_W'(1);
         if (rd_ok)
            rptr_reg <= rptr_reg + PTR_W'(1);
         occ_reg <= occ_next;
         if (wr_en && full && !rd_en)
            ovf_reg <= 1'b1;
         if (rd_en && empty)
            unf_reg <= 1'b1;
         // Registered from the next occupancy so it tracks occ with no lag.
         fetch_req_reg <= (occ_next <= LOW_WM_C);
         rd_valid_reg  <= rd_ok;
         // RAM output holds between pops; an underflow forces black instead.
         if (rd_en)
            pxl_zero_reg <= !rd_ok;
      end
   end

   assign rd_pxl                 = pxl_zero_reg ? '0 : ram_q;
   assign rd_valid               = rd_valid_reg;
   assign fetch_req              = fetch_req_reg;
   assign occ                    = occ_reg;
   assign lb_intf.bffr_overflow  = ovf_reg;
   assign lb_intf.bffr_underflow = unf_reg;

endmodule

// File: tb/tb_syn_vga_line_bffr.sv
// Directed self-checking bench for the VGA pixel line FIFO.
module tb_syn_vga_line_bffr;

   logic        clk_ir = 1'b0;
   logic        rst_il = 1'b0;
   logic        wr_en  = 1'b0;
   logic        rd_en  = 1'b0;
   logic [15:0] wr_pxl = '0;
   logic        fetch_req;
   logic [15:0] rd_pxl;
   logic        rd_valid;
   logic        full;
   logic        empty;
   logic [10:0] occ;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk_ir = ~clk_ir;

   syn_vga_drvr_lb_intf lb_if ();

   syn_vga_line_bffr dut (
      .clk_ir    (clk_ir),
      .rst_il    (rst_il),
      .lb_intf   (lb_if),
      .wr_en     (wr_en),
      .wr_pxl    (wr_pxl),
      .fetch_req (fetch_req),
      .rd_en     (rd_en),
      .rd_pxl    (rd_pxl),
      .rd_valid  (rd_valid),
      .full      (full),
      .empty     (empty),
      .occ       (occ)
   );

   typedef struct {
      logic        wr;
      logic        rd;
      logic [15:0] pxl;
      logic [10:0] exp_occ;
      logic        exp_vld;
      logic [15:0] exp_q;
      logic        exp_unf;
   } vec_t;

   vec_t vecs [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock with the given strobes; outputs are sampled 1 ns after the edge.
   task automatic cyc(input logic w, input logic r, input logic [15:0] p);
      wr_en  = w;
      rd_en  = r;
      wr_pxl = p;
      @(posedge clk_ir);
      #1;
      wr_en  = 1'b0;
      rd_en  = 1'b0;
   endtask

   task automatic chk_idle(input string tag, input logic exp_fetch);
      chk({tag, "_occ"},   32'(occ),                   32'd0);
      chk({tag, "_empty"}, 32'(empty),                 32'd1);
      chk({tag, "_full"},  32'(full),                  32'd0);
      chk({tag, "_ovf"},   32'(lb_if.bffr_overflow),   32'd0);
      chk({tag, "_unf"},   32'(lb_if.bffr_underflow),  32'd0);
      chk({tag, "_vld"},   32'(rd_valid),              32'd0);
      chk({tag, "_pxl"},   32'(rd_pxl),                32'd0);
      chk({tag, "_fetch"}, 32'(fetch_req),             32'(exp_fetch));
   endtask

   task automatic flush();
      lb_if.vga_drvr_en = 1'b0;
      cyc(1'b0, 1'b0, 16'h0);
      lb_if.vga_drvr_en = 1'b1;
   endtask

   initial begin
      //         wr    rd    pxl       occ   vld   q         unf
      vecs[0] = '{1'b1, 1'b0, 16'hA1A1, 11'd1, 1'b0, 16'h0000, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 16'hB2B2, 11'd2, 1'b0, 16'h0000, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 16'h0000, 11'd1, 1'b1, 16'hA1A1, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 16'h0000, 11'd1, 1'b0, 16'hA1A1, 1'b0};
      vecs[4] = '{1'b1, 1'b1, 16'hC3C3, 11'd1, 1'b1, 16'hB2B2, 1'b0};
      vecs[5] = '{1'b0, 1'b1, 16'h0000, 11'd0, 1'b1, 16'hC3C3, 1'b0};
      vecs[6] = '{1'b1, 1'b1, 16'hD4D4, 11'd1, 1'b0, 16'h0000, 1'b1};
      vecs[7] = '{1'b0, 1'b1, 16'h0000, 11'd0, 1'b1, 16'hD4D4, 1'b1};
      vecs[8] = '{1'b0, 1'b0, 16'h0000, 11'd0, 1'b0, 16'hD4D4, 1'b1};

      lb_if.vga_drvr_en = 1'b0;
      rst_il = 1'b0;
      repeat (3) @(posedge clk_ir);
      #1;
      chk_idle("reset", 1'b0);
      rst_il = 1'b1;
      lb_if.vga_drvr_en = 1'b1;

      // Short push/pop vectors from an empty, freshly enabled FIFO
      for (int i = 0; i < 9; i++) begin
         cyc(vecs[i].wr, vecs[i].rd, vecs[i].pxl);
         $display("vec %0d wr=%0b rd=%0b pxl=%h -> occ=%0d vld=%0b q=%h unf=%0b",
                  i, vecs[i].wr, vecs[i].rd, vecs[i].pxl, occ, rd_valid, rd_pxl,
                  lb_if.bffr_underflow);
         chk("vec_occ",   32'(occ),                  32'(vecs[i].exp_occ));
         chk("vec_empty", 32'(empty),                32'(vecs[i].exp_occ == 11'd0));
         chk("vec_vld",   32'(rd_valid),             32'(vecs[i].exp_vld));
         chk("vec_q",     32'(rd_pxl),               32'(vecs[i].exp_q));
         chk("vec_unf",   32'(lb_if.bffr_underflow), 32'(vecs[i].exp_unf));
         chk("vec_ovf",   32'(lb_if.bffr_overflow),  32'd0);
         chk("vec_fetch", 32'(fetch_req),            32'd1);
      end

      // One active line: 640 pixels in, 640 out in order
      flush();
      for (int i = 0; i < 640; i++)
         cyc(1'b1, 1'b0, 16'(i));
      chk("line_occ", 32'(occ), 32'd640);
      for (int i = 0; i < 640; i++) begin
         cyc(1'b0, 1'b1, 16'h0);
         chk("line_vld", 32'(rd_valid), 32'd1);
         chk("line_pxl", 32'(rd_pxl),   32'(i));
      end
      $display("line: 640 pixels streamed, occ=%0d", occ);
      chk("line_empty", 32'(empty),                32'd1);
      chk("line_ovf",   32'(lb_if.bffr_overflow),  32'd0);
      chk("line_unf",   32'(lb_if.bffr_underflow), 32'd0);

      // Low watermark crossings around 256
      for (int i = 0; i < 300; i++)
         cyc(1'b1, 1'b0, 16'(i));
      chk("wm_fetch_300", 32'(fetch_req), 32'd0);
      for (int i = 0; i < 43; i++)
         cyc(1'b0, 1'b1, 16'h0);
      chk("wm_occ_257",   32'(occ),       32'd257);
      chk("wm_fetch_257", 32'(fetch_req), 32'd0);
      cyc(1'b0, 1'b1, 16'h0);
      cyc(1'b0, 1'b0, 16'h0);
      chk("wm_occ_256",   32'(occ),       32'd256);
      chk("wm_fetch_256", 32'(fetch_req), 32'd1);
      cyc(1'b1, 1'b0, 16'h0);
      cyc(1'b0, 1'b0, 16'h0);
      chk("wm_fetch_257b", 32'(fetch_req), 32'd0);
      $display("watermark: occ=%0d fetch_req=%0b", occ, fetch_req);

      // Fill to full, push+pop while full, overflow, drain across the wrap
      flush();
      for (int i = 0; i < 1024; i++)
         cyc(1'b1, 1'b0, 16'(i));
      chk("full_occ",  32'(occ),                 32'd1024);
      chk("full_full", 32'(full),                32'd1);
      chk("full_ovf",  32'(lb_if.bffr_overflow), 32'd0);
      cyc(1'b1, 1'b1, 16'd1024);
      chk("both_occ", 32'(occ),                 32'd1024);
      chk("both_ovf", 32'(lb_if.bffr_overflow), 32'd0);
      chk("both_vld", 32'(rd_valid),            32'd1);
      chk("both_pxl", 32'(rd_pxl),              32'd0);
      cyc(1'b1, 1'b0, 16'hBEEF);
      chk("ovf_flag", 32'(lb_if.bffr_overflow), 32'd1);
      chk("ovf_occ",  32'(occ),                 32'd1024);
      for (int i = 0; i < 1024; i++) begin
         cyc(1'b0, 1'b1, 16'h0);
         chk("wrap_pxl", 32'(rd_pxl), 32'(i + 1));
      end
      chk("wrap_empty", 32'(empty),                32'd1);
      chk("wrap_ovf",   32'(lb_if.bffr_overflow),  32'd1);
      chk("wrap_unf",   32'(lb_if.bffr_underflow), 32'd0);
      $display("overflow/wrap: occ=%0d ovf=%0b", occ, lb_if.bffr_overflow);

      // Underflow on empty, then flags stay sticky
      cyc(1'b0, 1'b1, 16'h0);
      chk("unf_vld",  32'(rd_valid),             32'd0);
      chk("unf_pxl",  32'(rd_pxl),               32'd0);
      chk("unf_flag", 32'(lb_if.bffr_underflow), 32'd1);
      cyc(1'b1, 1'b0, 16'h0005);
      cyc(1'b0, 1'b1, 16'h0);
      chk("sticky_pxl", 32'(rd_pxl),               32'd5);
      chk("sticky_unf", 32'(lb_if.bffr_underflow), 32'd1);
      chk("sticky_ovf", 32'(lb_if.bffr_overflow),  32'd1);

      // One disabled cycle flushes everything; strobes are ignored meanwhile
      cyc(1'b1, 1'b0, 16'h0077);
      lb_if.vga_drvr_en = 1'b0;
      cyc(1'b1, 1'b1, 16'h1234);
      chk_idle("flush", 1'b0);
      lb_if.vga_drvr_en = 1'b1;
      cyc(1'b0, 1'b0, 16'h0);
      chk_idle("reenable", 1'b1);
      $display("flush: occ=%0d empty=%0b", occ, empty);

      // Asynchronous reset in the middle of a write burst
      for (int i = 0; i < 20; i++)
         cyc(1'b1, 1'b0, 16'(i));
      cyc(1'b1, 1'b1, 16'h0);
      chk("burst_occ", 32'(occ), 32'd20);
      wr_en = 1'b1;
      #2;
      rst_il = 1'b0;
      #1;
      chk_idle("async_rst", 1'b0);
      @(posedge clk_ir);
      #1;
      wr_en  = 1'b0;
      rst_il = 1'b1;
      chk("rst_hold_occ", 32'(occ), 32'd0);
      $display("async reset: occ=%0d", occ);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
